// File: rtl/jts16_sndmix_pkg.sv
// Shared types and constants for the JTS16 time-multiplexed stereo mixer.
package jts16_sndmix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    SAT  = 2'd3
  } state_t;

  // Gains are unsigned 4.4 fixed point
  localparam int         GAIN_FRAC  = 4;
  localparam logic [7:0] UNITY_GAIN = 8'h10;

  // Accumulator width: product of a W-bit sample and a (GW+1)-bit signed gain,
  // plus headroom for summing ch of them, so the channel walk can never wrap.
  function automatic int acc_width(input int w, input int gw, input int ch);
    return w + gw + $clog2(ch) + 1;
  endfunction

endpackage

// File: rtl/jts16_sndmix_sat.sv
// Removes the gain fraction from one accumulator and clamps it to a W-bit
// signed sample, flagging when the clamp was needed.
module jts16_sndmix_sat
  import jts16_sndmix_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 27
) (
  input  logic [AW-1:0] acc_i,
  output logic [W-1:0]  res_o,
  output logic          ovf_o
);

  localparam logic signed [AW-1:0] MAXV = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [AW-1:0] shifted;

  // Arithmetic shift (floor) then clamp to the signed W-bit range
  always_comb begin
    shifted = $signed(acc_i) >>> GAIN_FRAC;
    res_o   = shifted[W-1:0];
    ovf_o   = 1'b0;
    if (shifted > MAXV) begin
      res_o = MAXV[W-1:0];
      ovf_o = 1'b1;
    end else if (shifted < MINV) begin
      res_o = MINV[W-1:0];
      ovf_o = 1'b1;
    end
  end

endmodule

// File: rtl/jts16_sndmix.sv
// JTS16 stereo sound mixer: one shared multiply-accumulate path walks CH
// channels per output sample, then saturates and registers the result.
// Optional build macro JTS16_SNDMIX_PEAKHOLD_EN stretches the peak flag with
// a PKW-bit hold counter; without it peak reflects only the last sample.
module jts16_sndmix
  import jts16_sndmix_pkg::*;
#(
  parameter int CH  = 4,
  parameter int W   = 16,
  parameter int GW  = 8,
  parameter int PKW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            start,
  input  logic [CH*W-1:0] ch_l,
  input  logic [CH*W-1:0] ch_r,
  input  logic [CH*GW-1:0] gain,
  input  logic            mute,
  output logic [W-1:0]    mixed_l,
  output logic [W-1:0]    mixed_r,
  output logic            sample,
  output logic            busy,
  output logic            peak
);

  localparam int IW = $clog2(CH);
  localparam int AW = acc_width(W, GW, CH);
  localparam int PW = W + GW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(CH - 1);

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [AW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [W-1:0]          mixed_l_q, mixed_l_d, mixed_r_q, mixed_r_d;
  logic                  sample_q, sample_d;
  logic                  peak_q, peak_d;

  // Shadow copies of the inputs, frozen for the duration of a mix
  logic [CH*W-1:0]       sh_l_q, sh_r_q;
  logic [CH*GW-1:0]      sh_g_q;
  logic                  capture;

  logic signed [W-1:0]   smp_l, smp_r;
  logic signed [GW:0]    g_s;
  logic signed [PW-1:0]  prod_l, prod_r;

  logic [W-1:0]          sat_l, sat_r;
  logic                  ovf_l, ovf_r;

`ifdef JTS16_SNDMIX_PEAKHOLD_EN
  logic [PKW-1:0]        pk_cnt_q, pk_cnt_d;
`else
  logic                  unused_pkw;
  assign unused_pkw = (PKW > 0);
`endif

  assign capture = cen && start && (state_q == IDLE);

  // Gain is unsigned; a zero sign bit keeps 0xFF from reading as negative
  always_comb begin
    smp_l  = sh_l_q[idx_q*W +: W];
    smp_r  = sh_r_q[idx_q*W +: W];
    g_s    = {1'b0, sh_g_q[idx_q*GW +: GW]};
    prod_l = PW'(smp_l) * PW'(g_s);
    prod_r = PW'(smp_r) * PW'(g_s);
  end

  jts16_sndmix_sat #(.W(W), .AW(AW)) u_sat_l (
    .acc_i (acc_l_q),
    .res_o (sat_l),
    .ovf_o (ovf_l)
  );

  jts16_sndmix_sat #(.W(W), .AW(AW)) u_sat_r (
    .acc_i (acc_r_q),
    .res_o (sat_r),
    .ovf_o (ovf_r)
  );

  // Next-state and datapath updates; nothing moves unless cen is high
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    mixed_l_d = mixed_l_q;
    mixed_r_d = mixed_r_q;
    peak_d    = peak_q;
    sample_d  = 1'b0;
`ifdef JTS16_SNDMIX_PEAKHOLD_EN
    pk_cnt_d  = pk_cnt_q;
`endif
    if (cen) begin
      case (state_q)
        IDLE: begin
          if (start) state_d = LOAD;
        end
        LOAD: begin
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
        ACC: begin
          acc_l_d = acc_l_q + AW'(prod_l);
          acc_r_d = acc_r_q + AW'(prod_r);
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = SAT;
        end
        SAT: begin
          mixed_l_d = mute ? '0 : sat_l;
          mixed_r_d = mute ? '0 : sat_r;
          sample_d  = 1'b1;
          state_d   = IDLE;
`ifdef JTS16_SNDMIX_PEAKHOLD_EN
          if (ovf_l || ovf_r) begin
            pk_cnt_d = '1;
            peak_d   = 1'b1;
          end else begin
            peak_d = (pk_cnt_q != '0);
            if (pk_cnt_q != '0) pk_cnt_d = pk_cnt_q - 1'b1;
          end
`else
          peak_d = ovf_l || ovf_r;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control, accumulator and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mixed_l_q <= '0;
      mixed_r_q <= '0;
      sample_q  <= 1'b0;
      peak_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      mixed_l_q <= mixed_l_d;
      mixed_r_q <= mixed_r_d;
      sample_q  <= sample_d;
      peak_q    <= peak_d;
    end
  end

`ifdef JTS16_SNDMIX_PEAKHOLD_EN
  // Peak hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pk_cnt_q <= '0;
    else     pk_cnt_q <= pk_cnt_d;
  end
`endif

  // Input snapshot taken only when a mix is accepted from IDLE
  always_ff @(posedge clk) begin
    if (capture) begin
      sh_l_q <= ch_l;
      sh_r_q <= ch_r;
      sh_g_q <= gain;
    end
  end

  assign mixed_l = mixed_l_q;
  assign mixed_r = mixed_r_q;
  assign sample  = sample_q;
  assign peak    = peak_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_jts16_sndmix.sv
// Self-checking bench for jts16_sndmix (CH=4, W=16, GW=8, PKW=3).
module tb_jts16_sndmix;

  localparam int CH  = 4;
  localparam int W   = 16;
  localparam int GW  = 8;
  localparam int PKW = 3;
`ifdef JTS16_SNDMIX_PEAKHOLD_EN
  localparam int HOLD = (1 << PKW) - 1;
`else
  localparam int HOLD = 0;
`endif

  logic              clk = 1'b0;
  logic              rst, cen, start, mute;
  logic [CH*W-1:0]   ch_l, ch_r;
  logic [CH*GW-1:0]  gain;
  logic [W-1:0]      mixed_l, mixed_r;
  logic              sample, busy, peak;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pulses = 0;

  jts16_sndmix #(.CH(CH), .W(W), .GW(GW), .PKW(PKW)) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .start   (start),
    .ch_l    (ch_l),
    .ch_r    (ch_r),
    .gain    (gain),
    .mute    (mute),
    .mixed_l (mixed_l),
    .mixed_r (mixed_r),
    .sample  (sample),
    .busy    (busy),
    .peak    (peak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor(sum / 16) clamped to the signed W-bit range
  function automatic logic [W-1:0] sat_of(input longint s, output bit o);
    longint q, mx, mn;
    q  = s >>> 4;
    mx = (longint'(1) << (W - 1)) - 1;
    mn = -mx - 1;
    o  = 1'b0;
    if (q > mx) begin q = mx; o = 1'b1; end
    else if (q < mn) begin q = mn; o = 1'b1; end
    return q[W-1:0];
  endfunction

  function automatic void mix_calc(input logic [CH*W-1:0] l, input logic [CH*W-1:0] r,
                                   input logic [CH*GW-1:0] g, output logic [W-1:0] rl,
                                   output logic [W-1:0] rr, output bit s);
    longint sl, sr, gk;
    logic signed [W-1:0] a, b;
    bit ol, orr;
    sl = 0;
    sr = 0;
    for (int k = 0; k < CH; k++) begin
      a  = l[k*W +: W];
      b  = r[k*W +: W];
      gk = longint'({1'b0, g[k*GW +: GW]});
      sl += longint'(a) * gk;
      sr += longint'(b) * gk;
    end
    rl = sat_of(sl, ol);
    rr = sat_of(sr, orr);
    s  = ol | orr;
  endfunction

  // Model state: a mix accepted from idle completes CH+2 cen edges later
  bit           m_idle = 1'b1;
  int           m_cnt = 0;
  logic [W-1:0] p_l, p_r;
  bit           p_sat;
  logic [W-1:0] m_l = '0, m_r = '0;
  bit           m_sample = 1'b0;
  bit           seen_sat = 1'b0;
  int           n_clean = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_idle = 1'b1; m_cnt = 0; m_l = '0; m_r = '0;
        m_sample = 1'b0; seen_sat = 1'b0; n_clean = 0;
      end else begin
        m_sample = 1'b0;
        if (cen) begin
          if (m_idle) begin
            if (start) begin
              mix_calc(ch_l, ch_r, gain, p_l, p_r, p_sat);
              m_idle = 1'b0;
              m_cnt  = CH + 2;
            end
          end else begin
            m_cnt--;
            if (m_cnt == 0) begin
              m_l = mute ? '0 : p_l;
              m_r = mute ? '0 : p_r;
              m_sample = 1'b1;
              m_idle = 1'b1;
              if (p_sat) begin seen_sat = 1'b1; n_clean = 0; end
              else n_clean++;
            end
          end
        end
      end
      #1;
      if (sample === 1'b1) n_pulses++;
      chk("sample", longint'(sample), longint'(m_sample));
      chk("busy", longint'(busy), longint'(!m_idle));
      chk("mixed_l", longint'(mixed_l), longint'(m_l));
      chk("mixed_r", longint'(mixed_r), longint'(m_r));
      chk("peak", longint'(peak), longint'(seen_sat && (n_clean <= HOLD)));
    end
  end

  task automatic set_l(input int a, input int b, input int c, input int d);
    ch_l = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  task automatic set_r(input int a, input int b, input int c, input int d);
    ch_r = {W'(d), W'(c), W'(b), W'(a)};
  endtask

  task automatic set_g(input logic [GW-1:0] a, input logic [GW-1:0] b,
                       input logic [GW-1:0] c, input logic [GW-1:0] d);
    gain = {d, c, b, a};
  endtask

  // Called at a negedge; returns the number of negedges until the pulse is seen
  task automatic run_mix(output int cyc);
    int n0;
    n0 = n_pulses;
    start = 1'b1;
    cyc = 0;
    while (n_pulses == n0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
    end
    start = 1'b0;
    chk("mix_done", longint'(n_pulses - n0), 1);
  endtask

  task automatic idle_window(input int n, input int exp_pulses, input string name);
    int n0;
    n0 = n_pulses;
    repeat (n) @(negedge clk);
    chk(name, longint'(n_pulses - n0), longint'(exp_pulses));
  endtask

  initial begin
    int cyc, n0;
    rst = 1'b1; cen = 1'b1; start = 1'b0; mute = 1'b0;
    ch_l = '0; ch_r = '0; gain = '0;
    repeat (3) @(negedge clk);
    chk("rst_mixed_l", longint'(mixed_l), 0);
    chk("rst_mixed_r", longint'(mixed_r), 0);
    chk("rst_sample", longint'(sample), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_peak", longint'(peak), 0);
    rst = 1'b0;
    @(negedge clk);

    // Unity gain, four channels
    set_l(1000, 2000, -500, 0); set_r(100, 100, 100, 100);
    set_g(8'h10, 8'h10, 8'h10, 8'h10);
    run_mix(cyc);
    chk("unity_latency", longint'(cyc), 7);
    chk("unity_l", longint'(mixed_l), 2500);
    chk("unity_r", longint'(mixed_r), 400);
    chk("unity_peak", longint'(peak), 0);
    idle_window(10, 0, "unity_no_extra_pulse");

    // Positive and negative saturation
    set_l(32767, 32767, 32767, 32767); set_r(32767, 32767, 32767, 32767);
    set_g(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_mix(cyc);
    chk("satp_l", longint'(mixed_l), 'h7FFF);
    chk("satp_peak", longint'(peak), 1);
    set_l(-32768, -32768, -32768, -32768); set_r(-32768, -32768, -32768, -32768);
    run_mix(cyc);
    chk("satn_l", longint'(mixed_l), 'h8000);
    chk("satn_r", longint'(mixed_r), 'h8000);
    chk("satn_peak", longint'(peak), 1);

    // Half gain: shift floors toward minus infinity
    set_l(-1, 0, 0, 0); set_r(3, 0, 0, 0);
    set_g(8'h08, 8'h08, 8'h08, 8'h08);
    run_mix(cyc);
    chk("floor_l", longint'(mixed_l), 'hFFFF);
    chk("floor_r", longint'(mixed_r), 1);

    // Mixed pattern, model-checked
    set_l(1234, -4321, 777, -32768); set_r(-7, 30000, -15000, 99);
    set_g(8'h10, 8'h20, 8'h05, 8'h01);
    run_mix(cyc);

    // Start while busy, inputs changed after capture
    set_l(100, 200, 300, 400); set_r(10, 20, 30, 40);
    set_g(8'h10, 8'h10, 8'h10, 8'h10);
    n0 = n_pulses;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; set_l(5, 5, 5, 5);
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_start_pulses", longint'(n_pulses - n0), 1);
    chk("captured_l", longint'(mixed_l), 1000);
    chk("captured_r", longint'(mixed_r), 100);
    run_mix(cyc);
    chk("new_values_l", longint'(mixed_l), 20);

    // Mute
    mute = 1'b1;
    set_l(1000, 2000, 3000, 4000); set_r(-1000, 1, 2, 3);
    run_mix(cyc);
    chk("mute_l", longint'(mixed_l), 0);
    chk("mute_r", longint'(mixed_r), 0);
    mute = 1'b0;

    // Zero gain with full-scale inputs
    set_l(32767, 32767, 32767, 32767); set_r(-32768, -32768, -32768, -32768);
    set_g(8'h00, 8'h00, 8'h00, 8'h00);
    run_mix(cyc);
    chk("zero_gain_l", longint'(mixed_l), 0);
    chk("zero_gain_r", longint'(mixed_r), 0);
    chk("zero_gain_peak", longint'(peak), 0);

    // Start arriving on the completing edge is dropped
    set_l(1000, 2000, -500, 0); set_r(100, 100, 100, 100);
    set_g(8'h10, 8'h10, 8'h10, 8'h10);
    n0 = n_pulses;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("sat_edge_start_pulses", longint'(n_pulses - n0), 1);
    chk("sat_edge_busy", longint'(busy), 0);

    // Reset in the middle of the channel walk
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_l", longint'(mixed_l), 0);
    chk("midrst_r", longint'(mixed_r), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_sample", longint'(sample), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_window(12, 0, "midrst_no_pulse");
    run_mix(cyc);
    chk("postrst_latency", longint'(cyc), 7);
    chk("postrst_l", longint'(mixed_l), 2500);

    // Sparse clock enable
    set_l(-300, 600, 0, 0); set_r(7, 7, 7, 7);
    n0 = n_pulses;
    start = 1'b1;
    cyc = 0;
    while (n_pulses == n0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      cen = ~cen;
    end
    cen = 1'b1;
    chk("sparse_cen_done", longint'(n_pulses - n0), 1);
    chk("sparse_cen_l", longint'(mixed_l), 300);
    chk("sparse_cen_r", longint'(mixed_r), 28);
    @(negedge clk);

    // Peak hold after one saturating mix
    set_l(32767, 32767, 32767, 32767); set_r(0, 0, 0, 0);
    set_g(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_mix(cyc);
    chk("hold_sat_peak", longint'(peak), 1);
    set_l(10, 10, 10, 10);
    set_g(8'h10, 8'h10, 8'h10, 8'h10);
    for (int k = 1; k <= 8; k++) begin
      run_mix(cyc);
      chk($sformatf("hold_clean_%0d", k), longint'(peak), longint'(k <= HOLD));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
